// File: rtl/minmax_scheduler_if.sv
// Sample stream handshake between a sample source and minmax_scheduler.
// The source drives valid/data and the scheduler answers with ready.
interface minmax_scheduler_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;

  modport master (output sample_valid, output sample_data, input  sample_ready);
  modport slave  (input  sample_valid, input  sample_data, output sample_ready);
endinterface

// File: rtl/minmax_scheduler.sv
// Block max/min finder that shares a single unsigned 16-bit comparator.
// Each sample after the first takes one max-check and one min-check cycle.
module comparator (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt,
  output logic        lt
);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

module minmax_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   block_len,
  minmax_scheduler_if.slave  smp,
  output logic               busy,
  output logic               done,
  output logic [15:0]        max_val,
  output logic [15:0]        min_val,
  output logic [CNT_W-1:0]   max_idx,
  output logic [CNT_W-1:0]   min_idx
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [15:0]      samp_q, samp_d;
  logic [15:0]      wmax_q, wmax_d;
  logic [15:0]      wmin_q, wmin_d;
  logic [CNT_W-1:0] wmax_i_q, wmax_i_d;
  logic [CNT_W-1:0] wmin_i_q, wmin_i_d;
  logic [15:0]      max_val_q, max_val_d;
  logic [15:0]      min_val_q, min_val_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;

  logic [15:0] cmp_b;
  logic        cmp_gt;
  logic        cmp_lt;

  // The shared comparator sees the working max or min depending on phase.
  assign cmp_b = (state_q == CMP_MIN) ? wmin_q : wmax_q;

  comparator u_cmp (
    .a  (samp_q),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    samp_d    = samp_q;
    wmax_d    = wmax_q;
    wmin_d    = wmin_q;
    wmax_i_d  = wmax_i_q;
    wmin_i_d  = wmin_i_q;
    max_val_d = max_val_q;
    min_val_d = min_val_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (block_len != CNT_ZERO) begin
            len_d   = block_len;
            idx_d   = CNT_ZERO;
            state_d = FETCH;
          end else begin
            len_d    = CNT_ZERO;
            idx_d    = CNT_ZERO;
            samp_d   = 16'd0;
            wmax_d   = 16'd0;
            wmin_d   = 16'd0;
            wmax_i_d = CNT_ZERO;
            wmin_i_d = CNT_ZERO;
            state_d  = DONE;
          end
        end
      end
      FETCH: begin
        if (smp.sample_valid) begin
          if (idx_q == CNT_ZERO) begin
            wmax_d   = smp.sample_data;
            wmin_d   = smp.sample_data;
            wmax_i_d = CNT_ZERO;
            wmin_i_d = CNT_ZERO;
            if (len_q == CNT_ONE) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + CNT_ONE;
            end
          end else begin
            samp_d  = smp.sample_data;
            state_d = CMP_MAX;
          end
        end
      end
      CMP_MAX: begin
        // Strict compare: ties keep the earlier index.
        if (cmp_gt) begin
          wmax_d   = samp_q;
          wmax_i_d = idx_q;
        end
        state_d = CMP_MIN;
      end
      CMP_MIN: begin
        if (cmp_lt) begin
          wmin_d   = samp_q;
          wmin_i_d = idx_q;
        end
        if (idx_q == (len_q - CNT_ONE)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = FETCH;
        end
      end
      DONE: begin
        max_val_d = wmax_q;
        min_val_d = wmin_q;
        max_idx_d = wmax_i_q;
        min_idx_d = wmin_i_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      samp_q    <= '0;
      wmax_q    <= '0;
      wmin_q    <= '0;
      wmax_i_q  <= '0;
      wmin_i_q  <= '0;
      max_val_q <= '0;
      min_val_q <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      samp_q    <= samp_d;
      wmax_q    <= wmax_d;
      wmin_q    <= wmin_d;
      wmax_i_q  <= wmax_i_d;
      wmin_i_q  <= wmin_i_d;
      max_val_q <= max_val_d;
      min_val_q <= min_val_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign smp.sample_ready = (state_q == FETCH);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign max_val          = max_val_q;
  assign min_val          = min_val_q;
  assign max_idx          = max_idx_q;
  assign min_idx          = min_idx_q;
endmodule

// File: tb/tb_minmax_scheduler.sv
// Scoreboard bench for minmax_scheduler: stimulus pushes hand-computed
// results, a monitor pops and compares them on every done pulse.
module tb_minmax_scheduler;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  block_len;
  logic        busy;
  logic        done;
  logic [15:0] max_val;
  logic [15:0] min_val;
  logic [7:0]  max_idx;
  logic [7:0]  min_idx;

  minmax_scheduler_if smp_if ();

  minmax_scheduler #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .block_len (block_len),
    .smp       (smp_if.slave),
    .busy      (busy),
    .done      (done),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx)
  );

  typedef struct {
    logic [15:0] mx;
    logic [15:0] mn;
    logic [7:0]  mxi;
    logic [7:0]  mni;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  int          cyc;
  int          start_cyc;
  logic [15:0] vec [0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] mx, input logic [15:0] mn,
                          input logic [7:0] mxi, input logic [7:0] mni, input int c);
    exp_t e;
    e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic send_sample(input logic [15:0] d, input int bubbles, input bit extra_start);
    int guard;
    for (int i = 0; i < bubbles; i++) begin
      smp_if.sample_valid = 1'b0;
      start = (i == 0) ? extra_start : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    smp_if.sample_valid = 1'b1;
    smp_if.sample_data  = d;
    guard = 0;
    while (smp_if.sample_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      failures++;
      $display("FAIL sample_accept: ready never rose, expected accept of 0x%0h", d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      failures++;
      $display("FAIL idle_timeout: busy stuck at %0b, expected 0", busy);
    end
  endtask

  // Called at a negedge in IDLE; that cycle is cycle 0.
  task automatic run_block(input int n, input int bub_at, input int bub_n, input bit extra);
    start     = 1'b1;
    block_len = n[7:0];
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++)
      send_sample(vec[k], (k == bub_at) ? bub_n : 0, (k == bub_at) ? extra : 1'b0);
    smp_if.sample_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_max_val"}, int'(max_val), 0);
    chk({tag, "_min_val"}, int'(min_val), 0);
    chk({tag, "_max_idx"}, int'(max_idx), 0);
    chk({tag, "_min_idx"}, int'(min_idx), 0);
    chk({tag, "_ready"}, int'(smp_if.sample_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: checks done timing, then the results held in the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc - start_cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc - start_cyc, e.cyc);
          @(negedge clk);
          chk("max_val", int'(max_val), int'(e.mx));
          chk("min_val", int'(min_val), int'(e.mn));
          chk("max_idx", int'(max_idx), int'(e.mxi));
          chk("min_idx", int'(min_idx), int'(e.mni));
          $display("block len=%0d done@%0d max=0x%0h[%0d] min=0x%0h[%0d]",
                   block_len, e.cyc, max_val, max_idx, min_val, min_idx);
        end
      end
    end
  end

  initial begin
    int rdy_seen;
    checks = 0; failures = 0; cyc = 0; start_cyc = 0;
    rst = 1'b1; start = 1'b0; block_len = '0;
    smp_if.sample_valid = 1'b0; smp_if.sample_data = '0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vec = '{16'd5, 16'd9, 16'd2, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
    push_exp(16'd9, 16'd2, 8'd1, 8'd2, 11);
    run_block(4, -1, 0, 1'b0);

    vec = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    push_exp(16'hFFFF, 16'hFFFF, 8'd0, 8'd0, 2);
    run_block(1, -1, 0, 1'b0);

    // Zero-length block: ready must stay low throughout.
    push_exp(16'd0, 16'd0, 8'd0, 8'd0, 1);
    start = 1'b1; block_len = 8'd0; start_cyc = cyc;
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (smp_if.sample_ready === 1'b1) rdy_seen++;
    end
    chk("zero_len_ready", rdy_seen, 0);
    wait_idle();

    vec = '{16'h8000, 16'h0001, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    push_exp(16'h8000, 16'h0001, 8'd0, 8'd1, 10);
    run_block(3, 1, 2, 1'b1);
    repeat (3) @(negedge clk);
    chk("extra_start_ignored", int'(busy), 0);

    vec = '{16'd10, 16'd8, 16'd8, 16'd6, 16'd6, 16'd0, 16'd0, 16'd0};
    push_exp(16'd10, 16'd6, 8'd0, 8'd3, 14);
    run_block(5, -1, 0, 1'b0);

    // Mid-block reset with clk low: aborts with no done pulse.
    vec = '{16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd0, 16'd0, 16'd0};
    start = 1'b1; block_len = 8'd5; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    send_sample(vec[0], 0, 1'b0);
    send_sample(vec[1], 0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    smp_if.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vec = '{16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    push_exp(16'd4, 16'd3, 8'd1, 8'd0, 5);
    run_block(2, -1, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end
endmodule
